// File: rtl/key_conditioner.sv
// key_conditioner: per-key synchronizer, debounce FSM and edge pulses.
// Each raw key input is synchronized through two flops, normalized so that
// 1 = pressed, then filtered by an independent four-state debounce FSM.
// All outputs are registered and change on the same edge as the FSM state.
// Optional feature: define KEY_CONDITIONER_AUTOREPEAT_EN to build the
// per-key auto-repeat counters; otherwise key_repeat is tied to 0.
module key_conditioner #(
   parameter int N_KEYS          = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int ACTIVE_LOW      = 1,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_KEYS-1:0] key_raw,
   output logic [N_KEYS-1:0] key_state,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_repeat
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
   // Raw level that means "released"; the synchronizers reset to it.
   localparam logic             REL_LVL  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   typedef enum logic [1:0] {
      ST_RELEASED     = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_PRESSED      = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } key_st_t;

   logic [N_KEYS-1:0] sync1_r;
   logic [N_KEYS-1:0] sync2_r;
   logic [N_KEYS-1:0] sample_s;
   key_st_t           state_r     [N_KEYS];
   key_st_t           state_nxt_s [N_KEYS];
   logic [CNT_W-1:0]  cnt_r       [N_KEYS];
   logic [CNT_W-1:0]  cnt_nxt_s   [N_KEYS];
   logic [N_KEYS-1:0] level_nxt_s;
   logic [N_KEYS-1:0] press_nxt_s;
   logic [N_KEYS-1:0] release_nxt_s;
   logic [N_KEYS-1:0] key_state_r;
   logic [N_KEYS-1:0] key_press_r;
   logic [N_KEYS-1:0] key_release_r;

   // Saturating debounce counter increment; never wraps back to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == CNT_MAX) begin
         return v;
      end else begin
         return v + CNT_W'(1);
      end
   endfunction

   // Two-flop synchronizer; reset loads the released level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_r <= {N_KEYS{REL_LVL}};
         sync2_r <= {N_KEYS{REL_LVL}};
      end else begin
         sync1_r <= key_raw;
         sync2_r <= sync1_r;
      end
   end

   assign sample_s = (ACTIVE_LOW != 0) ? ~sync2_r : sync2_r;

   // Debounce next-state, counter and pulse decode for every key.
   always_comb begin
      for (int k = 0; k < N_KEYS; k++) begin
         state_nxt_s[k]   = state_r[k];
         cnt_nxt_s[k]     = {CNT_W{1'b0}};
         press_nxt_s[k]   = 1'b0;
         release_nxt_s[k] = 1'b0;
         case (state_r[k])
            ST_RELEASED: begin
               if (sample_s[k]) begin
                  state_nxt_s[k] = ST_PRESS_WAIT;
               end else begin
                  state_nxt_s[k] = ST_RELEASED;
               end
            end
            ST_PRESS_WAIT: begin
               if (!sample_s[k]) begin
                  state_nxt_s[k] = ST_RELEASED;
               end else if (cnt_r[k] == CNT_LAST) begin
                  state_nxt_s[k] = ST_PRESSED;
                  press_nxt_s[k] = 1'b1;
               end else begin
                  cnt_nxt_s[k] = sat_inc(cnt_r[k]);
               end
            end
            ST_PRESSED: begin
               if (!sample_s[k]) begin
                  state_nxt_s[k] = ST_RELEASE_WAIT;
               end else begin
                  state_nxt_s[k] = ST_PRESSED;
               end
            end
            ST_RELEASE_WAIT: begin
               if (sample_s[k]) begin
                  state_nxt_s[k] = ST_PRESSED;
               end else if (cnt_r[k] == CNT_LAST) begin
                  state_nxt_s[k]   = ST_RELEASED;
                  release_nxt_s[k] = 1'b1;
               end else begin
                  cnt_nxt_s[k] = sat_inc(cnt_r[k]);
               end
            end
            default: begin
               state_nxt_s[k] = ST_RELEASED;
            end
         endcase
         level_nxt_s[k] = (state_nxt_s[k] == ST_PRESSED) ||
                          (state_nxt_s[k] == ST_RELEASE_WAIT);
      end
   end

   // FSM state, counters and registered level/pulse outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < N_KEYS; k++) begin
            state_r[k] <= ST_RELEASED;
            cnt_r[k]   <= {CNT_W{1'b0}};
         end
         key_state_r   <= {N_KEYS{1'b0}};
         key_press_r   <= {N_KEYS{1'b0}};
         key_release_r <= {N_KEYS{1'b0}};
      end else begin
         for (int k = 0; k < N_KEYS; k++) begin
            state_r[k] <= state_nxt_s[k];
            cnt_r[k]   <= cnt_nxt_s[k];
         end
         key_state_r   <= level_nxt_s;
         key_press_r   <= press_nxt_s;
         key_release_r <= release_nxt_s;
      end
   end

   assign key_state   = key_state_r;
   assign key_press   = key_press_r;
   assign key_release = key_release_r;

`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
   localparam int              RPT_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int              RPT_W    = $clog2(RPT_MAX + 1);
   localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

   logic [RPT_W-1:0]  rpt_cnt_r [N_KEYS];
   logic [N_KEYS-1:0] rpt_first_r;
   logic [N_KEYS-1:0] key_repeat_r;

   // Repeat timer: restarts on an accepted press, first pulse after the
   // initial delay, then one per period while the debounced level is held.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < N_KEYS; k++) begin
            rpt_cnt_r[k] <= {RPT_W{1'b0}};
         end
         rpt_first_r  <= {N_KEYS{1'b0}};
         key_repeat_r <= {N_KEYS{1'b0}};
      end else begin
         for (int k = 0; k < N_KEYS; k++) begin
            if (press_nxt_s[k] || !level_nxt_s[k]) begin
               rpt_cnt_r[k]    <= {RPT_W{1'b0}};
               rpt_first_r[k]  <= 1'b0;
               key_repeat_r[k] <= 1'b0;
            end else if (!rpt_first_r[k] && (rpt_cnt_r[k] == DLY_LAST)) begin
               rpt_cnt_r[k]    <= {RPT_W{1'b0}};
               rpt_first_r[k]  <= 1'b1;
               key_repeat_r[k] <= 1'b1;
            end else if (rpt_first_r[k] && (rpt_cnt_r[k] == PER_LAST)) begin
               rpt_cnt_r[k]    <= {RPT_W{1'b0}};
               key_repeat_r[k] <= 1'b1;
            end else begin
               rpt_cnt_r[k]    <= rpt_cnt_r[k] + RPT_W'(1);
               key_repeat_r[k] <= 1'b0;
            end
         end
      end
   end

   assign key_repeat = key_repeat_r;
`else
   assign key_repeat = {N_KEYS{1'b0}};
`endif

endmodule
